// File: rtl/ad_cap_pkg.sv
// Shared types and helpers for the triggered ADC capture block.
package ad_cap_pkg;

  // Capture controller states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    READ  = 3'd4
  } cap_state_e;

  // Stored / streamed word: {otr, 1'b0, sample}.
  localparam int WORD_W   = 16;
  localparam int SAMPLE_W = WORD_W - 2;

  // Pack one ADC sample and its out-of-range flag into a buffer word.
  function automatic logic [WORD_W-1:0] pack_word(input logic otr,
                                                  input logic [SAMPLE_W-1:0] sample);
    return {otr, 1'b0, sample};
  endfunction

endpackage

// File: rtl/ad_cap_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
module ad_cap_ram
  import ad_cap_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_data_reg;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; output holds its value when re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/ad_trig_capture.sv
// Level/edge triggered ADC capture into a circular buffer with pre-trigger
// depth, followed by a valid/ready readout of one DEPTH-sample record.
module ad_trig_capture
  import ad_cap_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_otr,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] pre_len,
  output logic              busy,
  output logic              done,
  output logic              otr_flag,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   REC_LEN  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  cap_state_e state_reg, state_next;

  // Input pipeline: d1 is the sample being written, d2 the one before it.
  logic [DATA_W-1:0] d1_reg, d2_reg;
  logic              d1_otr_reg;

  // Trigger configuration latched on an accepted arm.
  logic [DATA_W-1:0] level_reg;
  logic              edge_reg;
  logic [ADDR_W-1:0] pre_len_reg;

  // Write side.
  logic [ADDR_W-1:0] wr_ptr_reg, fill_cnt_reg, post_cnt_reg;
  logic              otr_flag_reg;

  // Read side: RAM output stage (pipe) feeding the output register.
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   rd_cnt_reg;
  logic              pipe_vld_reg, pipe_last_reg;
  logic              m_valid_reg, m_last_reg;
  logic [WORD_W-1:0] m_data_reg;
  logic [WORD_W-1:0] ram_q, wr_word;

  logic arm_accept, wr_en, d1_ge, d2_ge, trig_hit, trig_take;
  logic xfer, pipe_take, rd_en, done_pulse, busy_comb;

  assign arm_accept = (state_reg == IDLE) && arm;
  assign wr_en      = (state_reg == FILL) || (state_reg == ARMED) || (state_reg == POST);

  // Unsigned threshold crossing between consecutive samples.
  assign d1_ge     = d1_reg >= level_reg;
  assign d2_ge     = d2_reg >= level_reg;
  assign trig_hit  = edge_reg ? (d2_ge && !d1_ge) : (!d2_ge && d1_ge);
  assign trig_take = (state_reg == ARMED) && trig_hit;

  // The RAM output acts as the skid slot: a new read is only issued when
  // the word currently held there is moving into the output register.
  assign xfer      = m_valid_reg && m_ready;
  assign pipe_take = pipe_vld_reg && (!m_valid_reg || m_ready);
  assign rd_en     = (state_reg == READ) && (rd_cnt_reg != REC_LEN) &&
                     (!pipe_vld_reg || pipe_take);

  assign wr_word = pack_word(d1_otr_reg, SAMPLE_W'(d1_reg));

  ad_cap_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (sys_clk),
    .we      (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_word),
    .re      (rd_en),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_q)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus busy/done decode.
  always_comb begin
    state_next = state_reg;
    done_pulse = 1'b0;
    busy_comb  = (state_reg != IDLE);
    unique case (state_reg)
      IDLE: begin
        if (arm) begin
          state_next = (pre_len == '0) ? ARMED : FILL;
        end
      end
      FILL: begin
        if (fill_cnt_reg == pre_len_reg - ADDR_W'(1)) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (trig_hit) begin
          state_next = (pre_len_reg == LAST_IDX) ? READ : POST;
        end
      end
      POST: begin
        if (post_cnt_reg == ADDR_W'(1)) begin
          state_next = READ;
        end
      end
      READ: begin
        if (xfer && m_last_reg) begin
          done_pulse = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Input sample pipeline.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      d1_reg     <= '0;
      d2_reg     <= '0;
      d1_otr_reg <= 1'b0;
    end else begin
      d1_reg     <= ad_data;
      d1_otr_reg <= ad_otr;
      d2_reg     <= d1_reg;
    end
  end

  // Configuration latch, write pointer, fill/post counters and sticky OTR.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level_reg    <= '0;
      edge_reg     <= 1'b0;
      pre_len_reg  <= '0;
      wr_ptr_reg   <= '0;
      fill_cnt_reg <= '0;
      post_cnt_reg <= '0;
      otr_flag_reg <= 1'b0;
    end else begin
      if (arm_accept) begin
        level_reg    <= trig_level;
        edge_reg     <= trig_edge;
        pre_len_reg  <= pre_len;
        wr_ptr_reg   <= '0;
        fill_cnt_reg <= '0;
        otr_flag_reg <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
        if (d1_otr_reg) begin
          otr_flag_reg <= 1'b1;
        end
      end
      if (state_reg == FILL) begin
        fill_cnt_reg <= fill_cnt_reg + ADDR_W'(1);
      end
      if (trig_take) begin
        post_cnt_reg <= LAST_IDX - pre_len_reg;
      end else if (state_reg == POST) begin
        post_cnt_reg <= post_cnt_reg - ADDR_W'(1);
      end
    end
  end

  // Read address generation; the record starts pre_len words before the
  // trigger sample's address, which is the write pointer at trigger time.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_ptr_reg    <= '0;
      rd_cnt_reg    <= '0;
      pipe_vld_reg  <= 1'b0;
      pipe_last_reg <= 1'b0;
    end else begin
      if (trig_take) begin
        rd_ptr_reg <= wr_ptr_reg - pre_len_reg;
        rd_cnt_reg <= '0;
      end else if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
        rd_cnt_reg <= rd_cnt_reg + (ADDR_W + 1)'(1);
      end
      if (rd_en) begin
        pipe_vld_reg  <= 1'b1;
        pipe_last_reg <= (rd_cnt_reg == LAST_CNT);
      end else if (pipe_take) begin
        pipe_vld_reg  <= 1'b0;
        pipe_last_reg <= 1'b0;
      end
    end
  end

  // Output register: loads from the RAM stage, holds while stalled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      if (pipe_take) begin
        m_valid_reg <= 1'b1;
        m_last_reg  <= pipe_last_reg;
        m_data_reg  <= ram_q;
      end else if (xfer) begin
        m_valid_reg <= 1'b0;
        m_last_reg  <= 1'b0;
      end
    end
  end

  assign busy     = busy_comb;
  assign done     = done_pulse;
  assign otr_flag = otr_flag_reg;
  assign m_data   = m_data_reg;
  assign m_valid  = m_valid_reg;
  assign m_last   = m_last_reg;

endmodule

// File: tb/tb_ad_trig_capture.sv
// Bench for ad_trig_capture (DEPTH = 16): table-driven captures, reset
// aborts and randomized captures against a sample-stream reference model.
module tb_ad_trig_capture;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int NS     = 300;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [DATA_W-1:0] ad_data = '0;
  logic              ad_otr = 1'b0;
  logic              arm = 1'b0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              trig_edge = 1'b0;
  logic [ADDR_W-1:0] pre_len = '0;
  logic              busy, done, otr_flag, m_valid, m_last;
  logic              m_ready = 1'b0;
  logic [15:0]       m_data;

  ad_trig_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .ad_data    (ad_data),
    .ad_otr     (ad_otr),
    .arm        (arm),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .pre_len    (pre_len),
    .busy       (busy),
    .done       (done),
    .otr_flag   (otr_flag),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Sample stream: samp[0] is presented the cycle before arm, samp[1]
  // together with arm, and so on one per cycle.
  logic [DATA_W-1:0] samp [NS];
  logic              sotr [NS];
  logic [15:0]       got_q [$];

  typedef struct {
    string name;
    int    pre;
    int    lvl;
    bit    edg;
    int    kind;
    bit    rnd_ready;
    bit    arm_again;
    int    exp_first;
    int    exp_at_pre;
    int    exp_last;
    bit    exp_otr;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // First stream index whose sample crosses the threshold relative to the
  // sample before it, searching only once pre samples have been stored.
  function automatic int find_trig(input int pre, input int lvl, input bit edg);
    for (int t = pre + 1; t < 250; t++) begin
      int a;
      int b;
      a = int'(samp[t-1]);
      b = int'(samp[t]);
      if (edg ? (a >= lvl && b < lvl) : (a < lvl && b >= lvl)) return t;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_word(input int idx);
    return {sotr[idx], 1'b0, samp[idx][13:0]};
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < NS; i++) begin
      samp[i] = DATA_W'(i);
      sotr[i] = 1'b0;
    end
  endtask

  task automatic fill_kind(input int kind);
    fill_ramp();
    if (kind == 1) begin
      for (int i = 0; i < NS; i++) begin
        if (i < 5) samp[i] = DATA_W'(140 - 5 * i);
        else if (i <= 35) samp[i] = DATA_W'(90 - 3 * (i - 5));
        else samp[i] = '0;
      end
    end else if (kind == 2) begin
      sotr[17] = 1'b1;
    end
  endtask

  task automatic do_abort(input int mode);
    #1;
    if (mode == 1) check("busy_before_abort", 32'(busy), 32'd1);
    else check("valid_before_abort", 32'(m_valid), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(m_valid), 32'd0);
    if (mode == 2) begin
      check("abort_data", 32'(m_data), 32'd0);
      check("abort_last", 32'(m_last), 32'd0);
    end
    arm = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    $display("capture abort mode=%0d reset applied", mode);
  endtask

  // One complete capture; abort_mode 1/2 resets in ARMED / mid-READ instead.
  task automatic run_capture(input string name, input int pre, input int lvl, input bit edg,
                             input bit rnd_ready, input bit arm_again, input int abort_mode);
    int  t, idx, n_done, last_bad, stall_bad, idle_bad, first_x, last_x, tmo;
    bit  finished, prev_stall, exp_otr;
    logic [15:0] prev_data;
    logic        prev_last;
    got_q.delete();
    t = find_trig(pre, lvl, edg);
    n_done = 0; last_bad = 0; stall_bad = 0; idle_bad = 0;
    first_x = -1; last_x = -1; finished = 0; prev_stall = 0;
    prev_data = '0; prev_last = 1'b0;
    @(posedge sys_clk); #1;
    ad_data = samp[0]; ad_otr = sotr[0]; m_ready = 1'b0; arm = 1'b0;
    @(posedge sys_clk); #1;
    ad_data = samp[1]; ad_otr = sotr[1]; arm = 1'b1;
    trig_level = DATA_W'(lvl); trig_edge = edg; pre_len = ADDR_W'(pre);
    @(posedge sys_clk); #1;
    arm = 1'b0;
    trig_level = ~trig_level; trig_edge = ~edg; pre_len = ADDR_W'(pre + 7);
    check("otr_clr_on_arm", 32'(otr_flag), 32'd0);
    check("busy_after_arm", 32'(busy), 32'd1);
    idx = 2;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ad_data = (idx < NS) ? samp[idx] : '0;
      ad_otr  = (idx < NS) ? sotr[idx] : 1'b0;
      idx++;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      arm = (arm_again && (cyc == 5 || got_q.size() == 3)) ? 1'b1 : 1'b0;
      if ((abort_mode == 1 && cyc == 10) || (abort_mode == 2 && got_q.size() == 5)) begin
        do_abort(abort_mode);
        return;
      end
      #1;
      if (prev_stall && !(m_valid && m_data == prev_data && m_last == prev_last)) stall_bad++;
      if (done) n_done++;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        if (m_last != (got_q.size() == DEPTH)) last_bad++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (done) begin
        finished = 1;
        break;
      end
      @(posedge sys_clk); #1;
    end
    arm = 1'b0;
    tmo = finished ? 0 : 1;
    check("capture_timeout", 32'(tmo), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge sys_clk); #1;
      m_ready = 1'b1;
      #1;
      if (busy || m_valid) idle_bad++;
      if (done) n_done++;
    end
    check("xfer_count", 32'(got_q.size()), 32'(DEPTH));
    check("done_count", 32'(n_done), 32'd1);
    check("last_flag", 32'(last_bad), 32'd0);
    check("stall_stable", 32'(stall_bad), 32'd0);
    check("idle_after", 32'(idle_bad), 32'd0);
    if (!rnd_ready && finished) check("throughput", 32'(last_x - first_x), 32'(DEPTH - 1));
    if (t < 0) begin
      check("trig_found", 32'd0, 32'd1);
    end else begin
      exp_otr = 1'b0;
      for (int i = 1; i <= t - pre + DEPTH - 1; i++) exp_otr |= sotr[i];
      check("otr_flag", 32'(otr_flag), 32'(exp_otr));
      for (int k = 0; k < DEPTH && k < got_q.size(); k++)
        check($sformatf("word%0d", k), 32'(got_q[k]), 32'(exp_word(t - pre + k)));
    end
    $display("capture %s pre=%0d lvl=%0d edge=%0d trig_idx=%0d words=%0d first=%h last=%h",
             name, pre, lvl, edg, t, got_q.size(),
             (got_q.size() > 0) ? got_q[0] : 16'h0,
             (got_q.size() > 0) ? got_q[got_q.size()-1] : 16'h0);
  endtask

  initial begin
    int t, pre, lvl, tries;
    bit edg;
    tbl[0] = '{"ramp_rise",   4,  20, 1'b0, 0, 1'b0, 1'b0, 16, 20, 31, 1'b0};
    tbl[1] = '{"fall_sine",   0, 100, 1'b1, 1, 1'b0, 1'b0, 90, 90, 45, 1'b0};
    tbl[2] = '{"pre15",      15,  50, 1'b0, 0, 1'b0, 1'b0, 35, 50, 50, 1'b0};
    tbl[3] = '{"otr_pulse",   4,  20, 1'b0, 2, 1'b0, 1'b0, 16, 20, 31, 1'b1};
    tbl[4] = '{"rand_ready",  4,  20, 1'b0, 0, 1'b1, 1'b0, 16, 20, 31, 1'b0};
    tbl[5] = '{"arm_busy",    4,  20, 1'b0, 0, 1'b0, 1'b1, 16, 20, 31, 1'b0};

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_otr_flag", 32'(otr_flag), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    sys_rst_n = 1'b1;

    foreach (tbl[r]) begin
      fill_kind(tbl[r].kind);
      run_capture(tbl[r].name, tbl[r].pre, tbl[r].lvl, tbl[r].edg,
                  tbl[r].rnd_ready, tbl[r].arm_again, 0);
      check({tbl[r].name, "_otr"}, 32'(otr_flag), 32'(tbl[r].exp_otr));
      if (got_q.size() == DEPTH) begin
        check({tbl[r].name, "_first"}, 32'(got_q[0][13:0]), 32'(tbl[r].exp_first));
        check({tbl[r].name, "_trigword"}, 32'(got_q[tbl[r].pre][13:0]), 32'(tbl[r].exp_at_pre));
        check({tbl[r].name, "_lastword"}, 32'(got_q[DEPTH-1][13:0]), 32'(tbl[r].exp_last));
        if (tbl[r].kind == 2) check("otr_word", 32'(got_q[1]), 32'h8011);
      end else begin
        check({tbl[r].name, "_len"}, 32'(got_q.size()), 32'(DEPTH));
      end
    end

    // Reset while ARMED, then a clean capture.
    fill_ramp();
    run_capture("abort_armed", 2, 1000, 1'b0, 1'b0, 1'b0, 1);
    run_capture("after_abort_armed", 4, 20, 1'b0, 1'b0, 1'b0, 0);
    // Reset mid-readout, then a clean capture.
    run_capture("abort_read", 4, 20, 1'b0, 1'b0, 1'b0, 2);
    run_capture("after_abort_read", 15, 50, 1'b0, 1'b1, 1'b0, 0);

    // Randomized captures against the stream model.
    for (int r = 0; r < 6; r++) begin
      tries = 0;
      do begin
        lvl = int'($urandom_range(16, 47));
        edg = 1'($urandom_range(0, 1));
        pre = int'($urandom_range(0, 15));
        for (int i = 0; i < NS; i++) begin
          samp[i] = DATA_W'($urandom_range(0, 63));
          sotr[i] = ($urandom_range(0, 7) == 0);
        end
        t = find_trig(pre, lvl, edg);
        tries++;
      end while (t < 0 && tries < 20);
      run_capture($sformatf("random%0d", r), pre, lvl, edg, 1'b1, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
